// File: rtl/instr_sequencer_if.sv
// Program ROM fetch interface for instr_sequencer.
//   rom_addr  [7:0]  fetch address (sequencer -> ROM)
//   rom_req          fetch request (sequencer -> ROM)
//   rom_data  [19:0] instruction word (ROM -> sequencer)
//   rom_valid        rom_data valid this cycle (ROM -> sequencer)
interface instr_sequencer_if;
  logic [7:0]  rom_addr;
  logic        rom_req;
  logic [19:0] rom_data;
  logic        rom_valid;

  modport master (output rom_addr, output rom_req, input rom_data, input rom_valid);
  modport slave  (input rom_addr, input rom_req, output rom_data, output rom_valid);
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches a 20-bit instruction from program ROM,
// decodes it and issues one cycle of write/PC-control strobes to the
// register/memory block.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc [7:0]            current program counter (fetch address)
//   rom                 ROM fetch interface (master side)
//   halt_req            stop before the next fetch
//   addr [4:0]          register/memory address
//   literal [7:0]       immediate operand
//   csrc [1:0]          write source select
//   wr_en               write/commit strobe (EXEC only)
//   CPC [1:0]           PC control: 0 hold, 1 +1, 2 conditional skip (EXEC only)
//   call/ret/pop/push   stack control strobes (EXEC only)
//   busy, halted        run status
//   illegal             sticky illegal-opcode flag
//   instr_count [7:0]   retired instruction count (wraps)
module instr_sequencer (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                pc,
  instr_sequencer_if.master         rom,
  input  logic                      halt_req,
  output logic [4:0]                addr,
  output logic [7:0]                literal,
  output logic [1:0]                csrc,
  output logic                      wr_en,
  output logic [1:0]                CPC,
  output logic                      call,
  output logic                      ret,
  output logic                      pop,
  output logic                      push,
  output logic                      busy,
  output logic                      halted,
  output logic                      illegal,
  output logic [7:0]                instr_count
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALTED} state_t;

  state_t      state;
  logic [3:0]  ir_op;
  logic [4:0]  ir_addr;
  logic [7:0]  ir_lit;

  logic [1:0]  d_csrc;
  logic [1:0]  d_cpc;
  logic        d_call, d_ret, d_pop, d_push;
  logic        d_legal;
  logic        unused_rsvd;

  assign unused_rsvd = ^rom.rom_data[15:13];

  // Fetch request is combinational so halt_req and rst suppress it immediately.
  assign rom.rom_addr = pc;
  assign rom.rom_req  = (state == FETCH) && !rst && !halt_req;

  always_comb begin
    d_csrc  = '0;
    d_cpc   = '0;
    d_call  = 1'b0;
    d_ret   = 1'b0;
    d_pop   = 1'b0;
    d_push  = 1'b0;
    d_legal = 1'b1;
    case (ir_op)
      4'h1: begin d_csrc = 2'b01; d_cpc = 2'd1; end
      4'h2: begin d_csrc = 2'b00; d_cpc = 2'd1; end
      4'h3: begin d_csrc = 2'b10; d_cpc = 2'd1; end
      4'h4: begin d_csrc = 2'b11; d_cpc = 2'd1; end
      4'h5: begin d_csrc = 2'b01; d_cpc = 2'd2; end
      4'h6: begin d_csrc = 2'b01; d_call = 1'b1; end
      4'h7: begin d_csrc = 2'b01; d_ret  = 1'b1; end
      4'h8: begin d_csrc = 2'b00; d_cpc = 2'd1; d_pop  = 1'b1; end
      4'h9: begin d_csrc = 2'b00; d_cpc = 2'd1; d_push = 1'b1; end
      default: d_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      ir_op       <= '0;
      ir_addr     <= '0;
      ir_lit      <= '0;
      addr        <= '0;
      literal     <= '0;
      csrc        <= '0;
      CPC         <= '0;
      wr_en       <= 1'b0;
      call        <= 1'b0;
      ret         <= 1'b0;
      pop         <= 1'b0;
      push        <= 1'b0;
      busy        <= 1'b1;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (halt_req) begin
            state  <= HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (rom.rom_valid) begin
            ir_op   <= rom.rom_data[19:16];
            ir_addr <= rom.rom_data[12:8];
            ir_lit  <= rom.rom_data[7:0];
            state   <= DECODE;
          end
        end
        DECODE: begin
          addr    <= ir_addr;
          literal <= ir_lit;
          csrc    <= d_csrc;
          if (d_legal) begin
            // Strobes are loaded here so they are high for exactly the EXEC cycle.
            CPC   <= d_cpc;
            call  <= d_call;
            ret   <= d_ret;
            pop   <= d_pop;
            push  <= d_push;
            wr_en <= 1'b1;
            state <= EXEC;
          end else begin
            state  <= HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
            if (ir_op >= 4'hA) illegal <= 1'b1;
          end
        end
        EXEC: begin
          CPC         <= '0;
          call        <= 1'b0;
          ret         <= 1'b0;
          pop         <= 1'b0;
          push        <= 1'b0;
          wr_en       <= 1'b0;
          instr_count <= instr_count + 8'd1;
          state       <= FETCH;
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: opcode table vectors, directed
// multi-cycle sequences and a randomized run against a transaction model.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pc;
  logic       halt_req;
  logic [4:0] addr;
  logic [7:0] literal;
  logic [1:0] csrc;
  logic       wr_en;
  logic [1:0] CPC;
  logic       call, ret, pop, push;
  logic       busy, halted, illegal;
  logic [7:0] instr_count;

  instr_sequencer_if rom_if ();

  instr_sequencer dut (
    .clk(clk), .rst(rst), .pc(pc), .rom(rom_if), .halt_req(halt_req),
    .addr(addr), .literal(literal), .csrc(csrc), .wr_en(wr_en), .CPC(CPC),
    .call(call), .ret(ret), .pop(pop), .push(push), .busy(busy),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] op;
    logic [1:0] csrc;
    logic [1:0] cpc;
    logic [3:0] stb;   // {call, ret, pop, push}
  } vec_t;
  vec_t tbl [9];

  // values captured by run_instr
  int         req_cnt, wr_cnt, wr_cycle, dec_wr, bad_addr, bad_idle;
  logic [1:0] c_csrc, c_cpc;
  logic [4:0] c_addr;
  logic [7:0] c_lit;
  logic [3:0] c_stb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Call at a drive point (just after posedge); returns at the next drive point.
  task automatic do_reset();
    rst = 1'b1; halt_req = 1'b0; rom_if.rom_valid = 1'b0;
    @(negedge clk);
    chk("rst_rom_req_low", rom_if.rom_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_addr_lit_csrc", {addr, literal, csrc}, 0);
    chk("rst_cpc_strobes", {CPC, wr_en, call, ret, pop, push}, 0);
    chk("rst_rom_addr", rom_if.rom_addr, pc);
    @(posedge clk); #1;
  endtask

  // Runs one instruction from a FETCH drive point with 'waits' idle ROM cycles.
  task automatic run_instr(input logic [19:0] d, input int waits);
    req_cnt = 0; wr_cnt = 0; wr_cycle = 0; dec_wr = 0; bad_addr = 0; bad_idle = 0;
    for (int i = 0; i < waits + 3; i++) begin
      if (i == waits) begin
        rom_if.rom_valid = 1'b1;
        rom_if.rom_data  = d;
      end else begin
        // rom_valid noise after acceptance must be ignored
        rom_if.rom_valid = (i > waits) ? 1'($urandom) : 1'b0;
        rom_if.rom_data  = 20'($urandom);
      end
      @(negedge clk);
      if (rom_if.rom_req) req_cnt++;
      if (rom_if.rom_req && rom_if.rom_addr !== pc) bad_addr++;
      if (i == waits + 1 && wr_en) dec_wr++;
      if ($countones({call, ret, pop, push}) > 1) bad_idle++;
      if (!wr_en && ({CPC, call, ret, pop, push} != 0)) bad_idle++;
      if (wr_en) begin
        wr_cnt++; wr_cycle = i + 1;
        c_csrc = csrc; c_cpc = CPC; c_addr = addr; c_lit = literal;
        c_stb = {call, ret, pop, push};
      end
      @(posedge clk); #1;
    end
    rom_if.rom_valid = 1'b0;
  endtask

  // Feed one opcode that ends in HALTED; checks the halt and the idle afterwards.
  task automatic run_stop(input logic [3:0] op, input logic exp_ill, input string nm);
    logic [7:0] cnt0;
    cnt0 = instr_count;
    rom_if.rom_valid = 1'b1;
    rom_if.rom_data  = {op, 16'h1234};
    @(negedge clk);
    @(posedge clk); #1;
    rom_if.rom_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_decode_not_halted"}, halted, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_halted"}, {halted, busy}, 2'b10);
    chk({nm, "_illegal"}, illegal, exp_ill);
    chk({nm, "_count_unchanged"}, instr_count, cnt0);
    bad_idle = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      rom_if.rom_valid = 1'($urandom);
      halt_req = 1'($urandom);
      @(negedge clk);
      if (rom_if.rom_req || wr_en || call || ret || pop || push || !halted) bad_idle++;
    end
    halt_req = 1'b0;
    chk({nm, "_stays_halted_quiet"}, bad_idle, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] d;
    logic [3:0]  op;
    int          fetch_from, exec_at;
    logic [7:0]  mcount;
    logic [19:0] stash;
    vec_t        e;

    tbl[0] = '{4'h1, 2'b01, 2'd1, 4'b0000};
    tbl[1] = '{4'h2, 2'b00, 2'd1, 4'b0000};
    tbl[2] = '{4'h3, 2'b10, 2'd1, 4'b0000};
    tbl[3] = '{4'h4, 2'b11, 2'd1, 4'b0000};
    tbl[4] = '{4'h5, 2'b01, 2'd2, 4'b0000};
    tbl[5] = '{4'h6, 2'b01, 2'd0, 4'b1000};
    tbl[6] = '{4'h7, 2'b01, 2'd0, 4'b0100};
    tbl[7] = '{4'h8, 2'b00, 2'd1, 4'b0010};
    tbl[8] = '{4'h9, 2'b00, 2'd1, 4'b0001};

    rst = 1'b1; halt_req = 1'b0; pc = 8'h00;
    rom_if.rom_valid = 1'b0; rom_if.rom_data = '0;
    do_reset();

    // zero-wait LDI
    pc = 8'h10;
    run_instr(20'h1_03_A5, 0);
    chk("ldi_wr_cycle", wr_cycle, 3);
    chk("ldi_wr_count", wr_cnt, 1);
    chk("ldi_fields", {c_addr, c_lit, c_csrc, c_cpc}, {5'h03, 8'hA5, 2'b01, 2'd1});
    chk("ldi_rom_addr", bad_addr, 0);
    chk("ldi_instr_count", instr_count, 1);
    chk("ldi_hold_fields", {addr, literal, csrc}, {5'h03, 8'hA5, 2'b01});

    // ROM wait states then LDA
    pc = 8'h22;
    run_instr(20'h3_1F_5C, 4);
    chk("wait_req_cycles", req_cnt, 5);
    chk("wait_wr_count", wr_cnt, 1);
    chk("wait_wr_cycle", wr_cycle, 7);
    chk("wait_csrc", c_csrc, 2'b10);
    chk("wait_rom_addr", bad_addr, 0);

    // opcode table
    do_reset();
    foreach (tbl[k]) begin
      pc = 8'($urandom);
      d = {tbl[k].op, 3'b101, 5'($urandom), 8'($urandom)};
      run_instr(d, k % 3);
      chk($sformatf("tbl%0h_wr", tbl[k].op), {wr_cnt[3:0], dec_wr[3:0]}, 8'h10);
      chk($sformatf("tbl%0h_dec", tbl[k].op), {c_csrc, c_cpc, c_stb},
          {tbl[k].csrc, tbl[k].cpc, tbl[k].stb});
      chk($sformatf("tbl%0h_operands", tbl[k].op), {c_addr, c_lit}, d[12:0]);
      chk($sformatf("tbl%0h_idle_strobes", tbl[k].op), bad_idle, 0);
    end
    chk("tbl_count", instr_count, 9);

    // CALL then RET
    do_reset();
    run_instr(20'h6_00_11, 0);
    chk("call_strobe", {c_stb, c_cpc, wr_cnt[1:0]}, {4'b1000, 2'd0, 2'd1});
    chk("call_onehot", bad_idle, 0);
    run_instr(20'h7_00_22, 1);
    chk("ret_strobe", {c_stb, c_cpc, wr_cnt[1:0]}, {4'b0100, 2'd0, 2'd1});
    chk("ret_onehot", bad_idle, 0);
    chk("call_ret_count", instr_count, 2);

    // illegal opcode, then reset clears it
    run_stop(4'hC, 1'b1, "ill");
    do_reset();
    chk("ill_cleared", illegal, 0);

    // HALT opcode
    run_instr(20'h2_00_00, 0);
    run_stop(4'h0, 1'b0, "haltop");
    do_reset();

    // halt_req while waiting in FETCH
    rom_if.rom_valid = 1'b0;
    @(negedge clk);
    chk("hreq_waiting_req", rom_if.rom_req, 1);
    @(posedge clk); #1;
    halt_req = 1'b1;
    rom_if.rom_valid = 1'b1; rom_if.rom_data = 20'h1_00_00;
    @(negedge clk);
    chk("hreq_req_dropped", rom_if.rom_req, 0);
    @(posedge clk); #1;
    halt_req = 1'b0;
    @(negedge clk);
    chk("hreq_halted", {halted, busy, wr_en, rom_if.rom_req}, 4'b1000);
    chk("hreq_no_exec", instr_count, 0);
    @(posedge clk); #1;
    rom_if.rom_valid = 1'b0;
    do_reset();

    // counter wrap
    for (int k = 0; k < 255; k++) run_instr({4'h1, 16'($urandom)}, 0);
    chk("wrap_255", instr_count, 255);
    run_instr(20'h1_00_01, 0);
    chk("wrap_0", instr_count, 0);

    // reset in EXEC wins over retirement
    do_reset();
    run_instr(20'h1_00_01, 0);
    run_instr(20'h1_00_02, 0);
    rom_if.rom_valid = 1'b1; rom_if.rom_data = 20'h8_04_33;
    @(negedge clk);
    @(posedge clk); #1;
    rom_if.rom_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_exec_seen", {wr_en, pop, instr_count}, {1'b1, 1'b1, 8'd2});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_count_zero", instr_count, 0);
    chk("mid_strobes_zero", {wr_en, CPC, call, ret, pop, push}, 0);
    chk("mid_fetch", {busy, halted, rom_if.rom_req}, 3'b101);
    @(posedge clk); #1;

    // randomized run against transaction model
    do_reset();
    fetch_from = 0; exec_at = -1; mcount = 8'd0; stash = '0;
    for (int n = 0; n < 600; n++) begin
      pc = 8'($urandom);
      rom_if.rom_valid = ($urandom_range(0, 2) != 0);
      rom_if.rom_data  = {4'($urandom_range(1, 9)), 16'($urandom)};
      @(negedge clk);
      chk("rnd_rom_req", rom_if.rom_req, n >= fetch_from);
      chk("rnd_wr_en", wr_en, n == exec_at);
      chk("rnd_count", instr_count, mcount);
      if (n == exec_at) begin
        op = stash[19:16];
        e  = tbl[op - 4'h1];
        chk("rnd_dec", {csrc, CPC, call, ret, pop, push}, {e.csrc, e.cpc, e.stb});
        chk("rnd_operands", {addr, literal}, stash[12:0]);
        mcount = mcount + 8'd1;
      end else begin
        chk("rnd_idle_strobes", {CPC, call, ret, pop, push}, 0);
      end
      if (n >= fetch_from && rom_if.rom_valid) begin
        stash = rom_if.rom_data;
        exec_at = n + 2;
        fetch_from = n + 3;
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high, and the ports are named clk and rst.
REQ-002 clk  input  1  rising-edge clock, shared with the register/memory block.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 pc  input  8  current program counter read back from the register/memory block.
REQ-005 rom_addr  output  8  program ROM address.
REQ-006 rom_req  output  1  fetch request.
REQ-007 rom_data  input  20  instruction word, with fields as follows:
  - [19:16] opcode
  - [15:13] reserved (ignored)
  - [12:8] addr
  - [7:0] literal
REQ-008 rom_valid  input  1  rom_data is valid this cycle.
REQ-009 halt_req  input  1  request to stop before the next fetch.
REQ-010 addr  output  5  register/memory address.
REQ-011 literal  output  8  immediate operand.
REQ-012 csrc  output  2  write source select: 00 = data_in, 01 = literal, 10 = ambain, 11 = datacee.
REQ-013 wr_en  output  1  write/commit strobe.
REQ-014 CPC  output  2  PC control: 0 = hold, 1 = +1, 2 = conditional skip.
REQ-015 call, ret, pop, push  output  1 each  control strobes.
REQ-016 busy  output  1  high in every state except HALTED.
REQ-017 halted  output  1  high in HALTED.
REQ-018 illegal  output  1  sticky illegal-opcode flag.
REQ-019 instr_count  output  8  count of retired instructions.

Function
REQ-020 The FSM SHALL have exactly four states: FETCH, DECODE, EXEC and HALTED.
REQ-021 FETCH SHALL behave as follows:
  - drive rom_addr = pc and rom_req = 1;
  - when rom_valid = 1, latch rom_data into the instruction register and go to DECODE;
  - otherwise stay in FETCH indefinitely.
REQ-022 If halt_req = 1 on entry to FETCH, or while waiting in FETCH, the block SHALL go to HALTED with rom_req = 0; halt_req is ignored in DECODE and EXEC.
REQ-023 DECODE SHALL last exactly one cycle: it registers addr, literal, csrc, CPC and the strobe values, drives no strobes, and goes to EXEC.
REQ-024 EXEC SHALL last exactly one cycle: it asserts wr_en and the decoded strobes, increments instr_count, and goes to FETCH.
REQ-025 Minimum latency SHALL be 3 cycles per instruction (rom_valid already high in FETCH); each further cycle of rom_valid low adds one cycle.
REQ-026 Opcode decoding SHALL be as follows (all strobes not listed = 0):
  - 0x1 LDI: csrc=01, CPC=1.
  - 0x2 LDD: csrc=00, CPC=1.
  - 0x3 LDA: csrc=10, CPC=1.
  - 0x4 LDC: csrc=11, CPC=1.
  - 0x5 SKNZ: csrc=01, CPC=2.
  - 0x6 CALL: call=1, csrc=01, CPC=0.
  - 0x7 RET: ret=1, csrc=01, CPC=0.
  - 0x8 POP: pop=1, csrc=00, CPC=1.
  - 0x9 PUSH: push=1, csrc=00, CPC=1.
REQ-027 Opcode 0x0 (HALT) SHALL go from DECODE directly to HALTED, with no EXEC cycle, no wr_en, and no instr_count increment.
REQ-028 Opcodes 0xA–0xF SHALL set illegal = 1 and go from DECODE to HALTED, with no wr_en and no instr_count increment.
REQ-029 Outside EXEC, wr_en, call, ret, pop and push SHALL all be 0, and CPC SHALL be 0.
REQ-030 At most one of call, ret, pop and push SHALL be high in any cycle.
REQ-031 addr, literal and csrc SHALL hold their last decoded values until the next DECODE.
REQ-032 instr_count SHALL be 8-bit unsigned and wrap 255 -> 0.
REQ-033 HALTED SHALL be left only by rst; rom_req, wr_en and all strobes SHALL be 0 in HALTED.
REQ-034 rom_data SHALL be sampled only in a FETCH cycle with rom_valid = 1; rom_valid in any other state SHALL be ignored.

Reset
REQ-035 When rst = 1 at a rising edge, in any state, the next cycle SHALL have:
  - state = FETCH, busy = 1;
  - halted = 0, illegal = 0, instr_count = 0;
  - addr = 0, literal = 0, csrc = 0, CPC = 0;
  - wr_en = call = ret = pop = push = 0;
  - rom_req = 0 during the reset cycle itself, and rom_addr = pc.
REQ-036 A reset asserted during EXEC SHALL suppress that cycle's retirement count if both arrive at the same edge: reset wins.

Verification
REQ-037 Zero-wait LDI: pc = 8'h10, rom_data = 20'h1_03_A5, rom_valid = 1 -> in EXEC (cycle 3) wr_en = 1, addr = 5'h03, literal = 8'hA5, csrc = 01, CPC = 1; instr_count = 1 afterwards.
REQ-038 ROM wait states: rom_valid low for 4 cycles, then LDA -> rom_req held for 5 cycles; wr_en pulses exactly once with csrc = 10 on cycle 7.
REQ-039 CALL then RET: CALL pulses call = 1 with CPC = 0 for one cycle; RET pulses ret = 1 with CPC = 0; both strobes never coincide; instr_count = 2.
REQ-040 Illegal opcode 0xC -> illegal = 1 and halted = 1 from the cycle after DECODE; no wr_en ever; rom_req stays 0 until rst; after rst, illegal = 0.
REQ-041 Counter wrap and halt: retire 256 LDI -> instr_count = 0; halt_req = 1 while waiting in FETCH -> HALTED the next cycle with no EXEC.
REQ-042 Mid-operation reset: rst asserted in the EXEC cycle -> next cycle FETCH, instr_count = 0, all strobes 0.
